mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS32 datapath. Sequences each instruction through
//  fetch/decode/execute/memory/writeback states and drives all datapath enables, mux selects
//  and the 2-bit ALUOp consumed by the ALU control decoder (00=add, 01=sub, 10=use funct).
//  Sits between the instruction register (Opcode) and the datapath; stalls on memory handshake.
// PARAMETERS
//  OPC_RTYPE  6'h00  R-type opcode
//  OPC_LW     6'h23  load word opcode
//  OPC_SW     6'h2B  store word opcode
//  OPC_BEQ    6'h04  branch-if-equal opcode
//  OPC_J      6'h02  jump opcode
//  OPC_ADDI   6'h08  add-immediate opcode (used only with CTRL_ADDI_EN)
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  Opcode      in   6  IR[31:26], valid from Decode onward
//  MemReady    in   1  memory done; qualifies Fetch, MemRead, MemWrite states
//  PCWrite     out  1  unconditional PC load
//  PCWriteCond out  1  PC load if ALU Zero
//  IorD        out  1  memory address select: 0=PC, 1=ALUOut
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write request
//  IRWrite     out  1  instruction register load
//  MemtoReg    out  1  reg write data: 0=ALUOut, 1=MDR
//  RegDst      out  1  reg write address: 0=rt, 1=rd
//  RegWrite    out  1  register file write enable
//  ALUSrcA     out  1  ALU A: 0=PC, 1=A reg
//  ALUSrcB     out  2  ALU B: 00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  ALUOp       out  2  to ALU control decoder
//  PCSource    out  2  PC next: 00=ALU result, 01=ALUOut, 10=jump target
//  IllegalOp   out  1  one-cycle pulse in Decode on unsupported opcode
//  State       out  4  current state encoding (debug/verification)
// BEHAVIOUR
//  - Moore FSM, one registered 4-bit state; outputs decoded from State, gated as noted. Any output
//    not listed for a state is 0.
//  - rst_n=0: State=FETCH(0) immediately; all other outputs forced 0 while rst_n low.
//    Reset mid-instruction abandons it; no memory/reg write may occur during reset.
//  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00;
//    IRWrite=PCWrite=MemReady. Stay while MemReady=0; else ->DECODE.
//  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Opcode: LW/SW->MEMADDR, RTYPE->EXECUTE,
//    BEQ->BRANCH, J->JUMP, ADDI->ADDIEXEC (macro only); other ->FETCH with IllegalOp=1.
//  - MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW->MEMRD, SW->MEMWR.
//  - MEMRD(3): MemRead=1, IorD=1; stay until MemReady=1, then ->MEMWB.
//  - MEMWB(4): RegWrite=1, RegDst=0, MemtoReg=1; ->FETCH.
//  - MEMWR(5): MemWrite=1, IorD=1; stay until MemReady=1, then ->FETCH.
//  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10; ->RCOMPLETE.
//  - RCOMPLETE(7): RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
//  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; ->FETCH.
//  - JUMP(9): PCWrite=1, PCSource=10; ->FETCH.
//  - Unused encodings (12-15, and 10-11 without macro): all outputs 0, ->FETCH next cycle.
//  - Zero-wait latency (MemReady=1) in cycles FETCH..last: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.
//    Each stall cycle adds one. Opcode only sampled in DECODE and MEMADDR.
//  - Request outputs (MemRead/MemWrite) held stable for the full stall; no deassert before MemReady.
// CONFIGURATION
//  CTRL_ADDI_EN defined: adds ADDIEXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 ->ADDICOMP(11):
//    RegWrite=1, RegDst=0, MemtoReg=0 ->FETCH.
//  CTRL_ADDI_EN undefined: states 10/11 absent; opcode 6'h08 treated as illegal (IllegalOp pulse).
// TESTING
//  1 rst_n low 3 cycles mid-MEMRD -> State=0, all outputs 0; release w/ MemReady=1 -> FETCH with
//    MemRead=1, IRWrite=1, PCWrite=1.
//  2 LW (6'h23), MemReady=1 -> States 0,1,2,3,4,0; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0.
//  3 SW (6'h2B), MemReady=0 for 2 cycles in MEMWR -> State 5 held 3 cycles, MemWrite=1, IorD=1
//    throughout; RegWrite never 1.
//  4 R-type add then BEQ -> EXECUTE ALUOp=10; BRANCH ALUOp=01, PCWriteCond=1, PCSource=01; J -> PCSource=10.
//  5 Opcode 6'h3F in DECODE -> IllegalOp=1 for exactly 1 cycle, next State=0, no writes.
//  6 Opcode 6'h08: with CTRL_ADDI_EN -> States 0,1,10,11,0, ALUSrcB=10 in 10; without -> IllegalOp pulse.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for the multicycle MIPS32 datapath. Sequences each
//   instruction through fetch / decode / execute / memory / writeback and
//   drives the datapath enables, mux selects and the 2-bit ALUOp
//   (00=add, 01=sub, 10=use funct). Stalls on the MemReady handshake.
//
// Configuration macro:
//   CTRL_ADDI_EN  - adds ADDIEXEC/ADDICOMP states for opcode 6'h08.
//                   When undefined, 6'h08 is decoded as an illegal opcode.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   Opcode[5:0]     IR[31:26], valid from DECODE onward
//   MemReady        memory done; qualifies FETCH, MEMRD and MEMWR
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA      1-bit datapath controls
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]  datapath mux selects
//   IllegalOp       one-cycle pulse in DECODE on an unsupported opcode
//   State[3:0]      current state encoding
//
// state      | meaning
// -----------+---------------------------------------------------
// FETCH (0)  | read instruction at PC, PC+4; wait for MemReady
// DECODE(1)  | register read, branch target into ALUOut
// MEMADDR(2) | effective address for LW/SW
// MEMRD (3)  | data read at ALUOut; wait for MemReady
// MEMWB (4)  | MDR -> rt
// MEMWR (5)  | data write at ALUOut; wait for MemReady
// EXECUTE(6) | R-type ALU operation
// RCOMPLETE(7)| ALUOut -> rd
// BRANCH(8)  | compare A/B, conditional PC load
// JUMP  (9)  | PC <- jump target
// ADDIEXEC(10)| A + imm          (CTRL_ADDI_EN only)
// ADDICOMP(11)| ALUOut -> rt     (CTRL_ADDI_EN only)

module mips_multicycle_ctrl #(
    parameter logic [5:0] OPC_RTYPE = 6'h00,
    parameter logic [5:0] OPC_LW    = 6'h23,
    parameter logic [5:0] OPC_SW    = 6'h2B,
    parameter logic [5:0] OPC_BEQ   = 6'h04,
    parameter logic [5:0] OPC_J     = 6'h02,
    parameter logic [5:0] OPC_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    // Encodings 10/11 are reserved for the ADDI states; without the macro
    // they are never entered and fall into the unused-encoding default.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADDR   = 4'd2,
        S_MEMRD     = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWR     = 4'd5,
        S_EXECUTE   = 4'd6,
        S_RCOMPLETE = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDIEXEC  = 4'd10,
        S_ADDICOMP  = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        IllegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC only load on the cycle the memory delivers.
                IRWrite = MemReady;
                PCWrite = MemReady;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OPC_LW,
                    OPC_SW:    state_d = S_MEMADDR;
                    OPC_RTYPE: state_d = S_EXECUTE;
                    OPC_BEQ:   state_d = S_BRANCH;
                    OPC_J:     state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
                    OPC_ADDI:  state_d = S_ADDIEXEC;
`else
                    OPC_ADDI: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
`endif
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Opcode is held by the IR; anything else here is a corrupted
                // instruction, so just restart.
                if (Opcode == OPC_LW) begin
                    state_d = S_MEMRD;
                end else if (Opcode == OPC_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_RCOMPLETE;
            end
            S_RCOMPLETE: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
`ifdef CTRL_ADDI_EN
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDICOMP;
            end
            S_ADDICOMP: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase

        // No request or write may escape while reset is held.
        if (!rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            IllegalOp   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed instruction sequences with a
// per-cycle expected state / control-vector scoreboard.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

`ifdef CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .IllegalOp  (IllegalOp),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Control vector order:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic mr,
                                            input logic ill, input logic run);
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        if (run) begin
            case (st)
                4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
                4'd1:  begin asb = 2'b11; end
                4'd2:  begin asa = 1; asb = 2'b10; end
                4'd3:  begin mrd = 1; iord = 1; end
                4'd4:  begin rw = 1; m2r = 1; end
                4'd5:  begin mwr = 1; iord = 1; end
                4'd6:  begin asa = 1; aop = 2'b10; end
                4'd7:  begin rw = 1; rdst = 1; end
                4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
                4'd9:  begin pcw = 1; pcs = 2'b10; end
                4'd10: begin asa = 1; asb = 2'b10; end
                4'd11: begin rw = 1; end
                default: ;
            endcase
        end
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill & run};
    endfunction

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expectation, compare on the falling edge.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic ill, input logic run);
        exp_t        e;
        logic [16:0] obs;
        rst_n    = run;
        Opcode   = op;
        MemReady = mr;
        e.st     = st;
        e.outs   = exp_vec(st, mr, ill, run);
        sb.push_back(e);
        @(negedge clk);
        e   = sb.pop_front();
        obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
        n_total++;
        assert (State === e.st) n_pass++;
        else $error("FAIL state t=%0t observed=%0d expected=%0d", $time, State, e.st);
        n_total++;
        assert (obs === e.outs) n_pass++;
        else $error("FAIL ctrl state=%0d t=%0t observed=%b expected=%b", e.st, $time, obs, e.outs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = 6'h00;
        MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset: state 0, every output 0 even with MemReady high.
        cyc(6'h23, 1, 4'd0, 0, 0);
        cyc(6'h23, 1, 4'd0, 0, 0);

        // LW, zero wait: 0,1,2,3,4
        cyc(6'h23, 1, 4'd0, 0, 1);
        cyc(6'h23, 1, 4'd1, 0, 1);
        cyc(6'h23, 1, 4'd2, 0, 1);
        cyc(6'h23, 1, 4'd3, 0, 1);
        cyc(6'h23, 1, 4'd4, 0, 1);

        // LW with fetch stall, then reset asserted mid-MEMRD for 3 cycles.
        cyc(6'h23, 0, 4'd0, 0, 1);
        cyc(6'h23, 1, 4'd0, 0, 1);
        cyc(6'h23, 1, 4'd1, 0, 1);
        cyc(6'h23, 1, 4'd2, 0, 1);
        cyc(6'h23, 0, 4'd3, 0, 1);
        cyc(6'h23, 0, 4'd3, 0, 1);
        cyc(6'h23, 1, 4'd0, 0, 0);
        cyc(6'h23, 1, 4'd0, 0, 0);
        cyc(6'h23, 1, 4'd0, 0, 0);

        // Release with MemReady=1: FETCH with MemRead/IRWrite/PCWrite.
        cyc(6'h2B, 1, 4'd0, 0, 1);

        // SW with two stall cycles in MEMWR.
        cyc(6'h2B, 1, 4'd1, 0, 1);
        cyc(6'h2B, 1, 4'd2, 0, 1);
        cyc(6'h2B, 0, 4'd5, 0, 1);
        cyc(6'h2B, 0, 4'd5, 0, 1);
        cyc(6'h2B, 1, 4'd5, 0, 1);

        // R-type
        cyc(6'h00, 1, 4'd0, 0, 1);
        cyc(6'h00, 1, 4'd1, 0, 1);
        cyc(6'h00, 1, 4'd6, 0, 1);
        cyc(6'h00, 1, 4'd7, 0, 1);

        // BEQ
        cyc(6'h04, 1, 4'd0, 0, 1);
        cyc(6'h04, 1, 4'd1, 0, 1);
        cyc(6'h04, 1, 4'd8, 0, 1);

        // J
        cyc(6'h02, 1, 4'd0, 0, 1);
        cyc(6'h02, 1, 4'd1, 0, 1);
        cyc(6'h02, 1, 4'd9, 0, 1);

        // Illegal opcode: one-cycle pulse, back to FETCH.
        cyc(6'h3F, 1, 4'd0, 0, 1);
        cyc(6'h3F, 1, 4'd1, 1, 1);

        // ADDI
        cyc(6'h08, 1, 4'd0, 0, 1);
        cyc(6'h08, 1, 4'd1, !ADDI_EN, 1);
        if (ADDI_EN) begin
            cyc(6'h08, 1, 4'd10, 0, 1);
            cyc(6'h08, 1, 4'd11, 0, 1);
        end
        cyc(6'h00, 1, 4'd0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
